inference_sequencer: RTL

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

---
 rtl/inference_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
//
// Sequences one inference at a time through the neural-network datapath: it
// waits for a software START request, launches the network with a one-cycle
// strobe, waits for the completion strobe (bounded by a timeout), captures the
// solution vector, and holds it until software acknowledges it.
//
// Ports
//   CLK             in   1          clock, rising edge
//   rstn            in   1          synchronous active-low reset
//   CONFIG_DONE     in   1          weights/biases programmed (level)
//   START           in   1          CSR level; each rising edge requests a run
//   ACK_READ        in   1          CSR level; each rising edge acks result/errors
//   NET_VALID_IN    out  1          one-cycle launch strobe to the network
//   NET_VALID_OUT   in   1          network completion strobe
//   NET_VALUES_OUT  in   OUT_WIDTH  network solution, valid with NET_VALID_OUT
//   RESULT          out  OUT_WIDTH  last captured solution
//   RESULT_VALID    out  1          RESULT not yet acknowledged
//   BUSY            out  1          inference in flight (LAUNCH or WAIT)
//   CONFIG_ERR      out  1          sticky: START requested while unconfigured
//   TIMEOUT_ERR     out  1          sticky: network did not answer in time
//   RUN_COUNT       out  CNT_WIDTH  completed inferences, wraps
//   STATE           out  2          current FSM state, for debug
//
// State table
//   state  | meaning
//   IDLE   | waiting for a START edge
//   LAUNCH | NET_VALID_IN pulsed, timeout counter cleared
//   WAIT   | counting cycles until NET_VALID_OUT or timeout
//   DONE   | RESULT held valid until an ACK_READ edge
// -----------------------------------------------------------------------------
module inference_sequencer #(
  parameter int OUT_WIDTH      = 40,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 CLK,
  input  logic                 rstn,
  input  logic                 CONFIG_DONE,
  input  logic                 START,
  input  logic                 ACK_READ,
  output logic                 NET_VALID_IN,
  input  logic                 NET_VALID_OUT,
  input  logic [OUT_WIDTH-1:0] NET_VALUES_OUT,
  output logic [OUT_WIDTH-1:0] RESULT,
  output logic                 RESULT_VALID,
  output logic                 BUSY,
  output logic                 CONFIG_ERR,
  output logic                 TIMEOUT_ERR,
  output logic [CNT_WIDTH-1:0] RUN_COUNT,
  output logic [1:0]           STATE
);

  // Counter must hold 0 .. TIMEOUT_CYCLES-1.
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_WAIT   = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic             start_q;
  logic             ack_q;
  logic             start_edge;
  logic             ack_edge;
  logic [TMO_W-1:0] tmo_cnt;

  logic tmo_clr;
  logic tmo_inc;
  logic capture;
  logic rv_clr;
  logic cfg_err_set;
  logic tmo_err_set;
  logic launch;

  assign start_edge = START & ~start_q;
  assign ack_edge   = ACK_READ & ~ack_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    tmo_clr     = 1'b0;
    tmo_inc     = 1'b0;
    capture     = 1'b0;
    rv_clr      = 1'b0;
    cfg_err_set = 1'b0;
    tmo_err_set = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          if (CONFIG_DONE) begin
            state_nxt = ST_LAUNCH;
          end else begin
            cfg_err_set = 1'b1;
          end
        end
      end

      ST_LAUNCH: begin
        launch    = 1'b1;
        tmo_clr   = 1'b1;
        state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        tmo_inc = 1'b1;
        // A completion in the last allowed cycle still counts as on time.
        if (NET_VALID_OUT) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_err_set = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (ack_edge) begin
          rv_clr    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      start_q      <= 1'b0;
      ack_q        <= 1'b0;
      tmo_cnt      <= '0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      RUN_COUNT    <= '0;
      CONFIG_ERR   <= 1'b0;
      TIMEOUT_ERR  <= 1'b0;
    end else begin
      start_q <= START;
      ack_q   <= ACK_READ;

      if (tmo_clr) begin
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (capture) begin
        RESULT       <= NET_VALUES_OUT;
        RESULT_VALID <= 1'b1;
        RUN_COUNT    <= RUN_COUNT + CNT_WIDTH'(1);
      end else if (rv_clr) begin
        RESULT_VALID <= 1'b0;
      end

      // Set has priority over an acknowledge landing in the same cycle.
      if (cfg_err_set) begin
        CONFIG_ERR <= 1'b1;
      end else if (ack_edge) begin
        CONFIG_ERR <= 1'b0;
      end

      if (tmo_err_set) begin
        TIMEOUT_ERR <= 1'b1;
      end else if (ack_edge) begin
        TIMEOUT_ERR <= 1'b0;
      end
    end
  end

  assign NET_VALID_IN = launch;
  assign BUSY         = (state == ST_LAUNCH) || (state == ST_WAIT);
  assign STATE        = state;

endmodule
